// File: rtl/image_transpose_buffer.sv
// Whole-frame buffer: accepts one raster-order IMG_W x IMG_H frame on In1, then
// replays it on Out1 column-major (TRANSPOSE=1) or raster order (TRANSPOSE=0).
module image_transpose_buffer #(
    parameter int DATA_W    = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int TRANSPOSE = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic [15:0]       In1_COUNT,
    input  logic              In1_SEND,
    output logic              In1_ACK,
    output logic [DATA_W-1:0] Out1_DATA,
    output logic [15:0]       Out1_COUNT,
    output logic              Out1_SEND,
    input  logic              Out1_RDY,
    input  logic              Out1_ACK
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t            state_q;
    logic              run_q;
    logic [XW-1:0]     wr_x_q, rd_c_q;
    logic [YW-1:0]     wr_y_q, rd_r_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_addr, rd_addr;
    logic              wr_en, rd_en;

    // Count/ack sideband from the token protocol carries nothing this block needs.
    logic unused_inputs;
    assign unused_inputs = ^{In1_COUNT, Out1_ACK};

    assign wr_en   = run_q && (state_q == FILL) && In1_SEND;
    assign rd_en   = run_q && (state_q == DRAIN) && Out1_RDY;
    assign wr_addr = AW'(int'(wr_y_q) * IMG_W + int'(wr_x_q));
    assign rd_addr = AW'(int'(rd_r_q) * IMG_W + int'(rd_c_q));

    assign In1_ACK    = wr_en;
    assign Out1_SEND  = rd_en;
    assign Out1_COUNT = rd_en ? 16'h0001 : 16'h0000;
    assign Out1_DATA  = (run_q && state_q == DRAIN) ? mem[rd_addr] : '0;

    // Storage is deliberately left out of reset; a partial frame is simply overwritten.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= In1_DATA;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= FILL;
            run_q   <= 1'b0;
            wr_x_q  <= '0;
            wr_y_q  <= '0;
            rd_c_q  <= '0;
            rd_r_q  <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                FILL: begin
                    if (wr_en) begin
                        if (wr_x_q == X_LAST) begin
                            wr_x_q <= '0;
                            if (wr_y_q == Y_LAST) begin
                                wr_y_q  <= '0;
                                state_q <= DRAIN;
                            end else begin
                                wr_y_q <= wr_y_q + YW'(1);
                            end
                        end else begin
                            wr_x_q <= wr_x_q + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        // Rows advance innermost when transposing, columns otherwise.
                        if (TRANSPOSE != 0) begin
                            if (rd_r_q == Y_LAST) begin
                                rd_r_q <= '0;
                                if (rd_c_q == X_LAST) begin
                                    rd_c_q  <= '0;
                                    state_q <= FILL;
                                end else begin
                                    rd_c_q <= rd_c_q + XW'(1);
                                end
                            end else begin
                                rd_r_q <= rd_r_q + YW'(1);
                            end
                        end else begin
                            if (rd_c_q == X_LAST) begin
                                rd_c_q <= '0;
                                if (rd_r_q == Y_LAST) begin
                                    rd_r_q  <= '0;
                                    state_q <= FILL;
                                end else begin
                                    rd_r_q <= rd_r_q + YW'(1);
                                end
                            end else begin
                                rd_c_q <= rd_c_q + XW'(1);
                            end
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_image_transpose_buffer.sv
// Directed bench: a 4x3 transposing instance (T1-T5) and a 1x5 raster instance (T6).
module tb_image_transpose_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0]  a_in_data, a_out_data;
    logic [15:0] a_out_count;
    logic        a_in_send, a_in_ack, a_out_send, a_out_rdy;

    logic [7:0]  b_in_data, b_out_data;
    logic [15:0] b_out_count;
    logic        b_in_send, b_in_ack, b_out_send, b_out_rdy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_t[12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};

    image_transpose_buffer #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .TRANSPOSE(1)) dut_a (
        .CLK(clk), .RESET(rst_n),
        .In1_DATA(a_in_data), .In1_COUNT(16'd12), .In1_SEND(a_in_send), .In1_ACK(a_in_ack),
        .Out1_DATA(a_out_data), .Out1_COUNT(a_out_count), .Out1_SEND(a_out_send),
        .Out1_RDY(a_out_rdy), .Out1_ACK(1'b0)
    );

    image_transpose_buffer #(.DATA_W(8), .IMG_W(1), .IMG_H(5), .TRANSPOSE(0)) dut_b (
        .CLK(clk), .RESET(rst_n),
        .In1_DATA(b_in_data), .In1_COUNT(16'd5), .In1_SEND(b_in_send), .In1_ACK(b_in_ack),
        .Out1_DATA(b_out_data), .Out1_COUNT(b_out_count), .Out1_SEND(b_out_send),
        .Out1_RDY(b_out_rdy), .Out1_ACK(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Feed pixels base..base+11 into dut_a, optionally stalling gap_len cycles after index gap_after.
    task automatic feed_a(input int base, input int gap_after, input int gap_len);
        a_out_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_in_send = 1'b1;
            a_in_data = 8'(base + i);
            @(negedge clk);
            chk("fill_ack", a_in_ack, 1);
            chk("fill_no_send", a_out_send, 0);
            step();
            if (i == gap_after) begin
                a_in_send = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    chk("stall_ack", a_in_ack, 0);
                    step();
                end
            end
        end
        a_in_send = 1'b0;
    endtask

    // Drain stop_after tokens from dut_a; toggle selects RDY pattern 1,0,1,0...
    task automatic drain_a(input int base, input bit toggle, input int stop_after);
        int got = 0;
        int cyc = 0;
        while (got < stop_after && cyc < 60) begin
            a_out_rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            chk("drain_no_ack", a_in_ack, 0);
            chk("send_vs_rdy", a_out_send, a_out_rdy);
            if (a_out_rdy) begin
                chk("out_data", a_out_data, 32'(base + exp_t[got]));
                chk("out_count", a_out_count, 1);
                got++;
            end else begin
                chk("idle_count", a_out_count, 0);
            end
            step();
            cyc++;
        end
        chk("drain_tokens", got, stop_after);
        a_out_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_send = 1'b1; a_in_data = 8'h55; a_out_rdy = 1'b1;
        b_in_send = 1'b0; b_in_data = 8'h00; b_out_rdy = 1'b0;

        // Reset: everything quiet despite active requests.
        repeat (2) @(negedge clk);
        chk("rst_ack", a_in_ack, 0);
        chk("rst_send", a_out_send, 0);
        chk("rst_data", a_out_data, 0);
        chk("rst_count", a_out_count, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("pre_run_ack", a_in_ack, 0);
        step();

        // T1: plain transpose with RDY=1.
        feed_a(0, -1, 0);
        drain_a(0, 1'b0, 12);

        // T2: RDY toggling.
        feed_a(0, -1, 0);
        drain_a(0, 1'b1, 12);

        // T3: input stall of 3 cycles after pixel 5.
        feed_a(0, 5, 3);
        drain_a(0, 1'b0, 12);

        // T4: back-to-back frames with In1_SEND held high through the drain.
        feed_a(0, -1, 0);
        a_in_send = 1'b1;
        a_in_data = 8'd100;
        drain_a(0, 1'b0, 12);
        feed_a(100, -1, 0);
        drain_a(100, 1'b0, 12);

        // T5: reset after 5 output tokens, then a fresh frame.
        feed_a(0, -1, 0);
        drain_a(0, 1'b0, 5);
        a_out_rdy = 1'b1;
        a_in_send = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_send", a_out_send, 0);
        chk("mid_rst_ack", a_in_ack, 0);
        chk("mid_rst_count", a_out_count, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ack", a_in_ack, 0);
        step();
        feed_a(20, -1, 0);
        drain_a(20, 1'b0, 12);

        // T6: 1x5 raster pass-through on dut_b.
        b_out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_in_send = 1'b1;
            b_in_data = 8'(7 + i);
            @(negedge clk);
            chk("b_fill_ack", b_in_ack, 1);
            chk("b_fill_no_send", b_out_send, 0);
            step();
        end
        b_in_send = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("b_send", b_out_send, 1);
            chk("b_data", b_out_data, 32'(7 + k));
            chk("b_count", b_out_count, 1);
            step();
        end
        @(negedge clk);
        chk("b_back_to_fill", b_out_send, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
